// File: rtl/adc_interleave_ctrl_pkg.sv
// Shared types and constants for the 2-channel interleaved ADC sequencer.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP0 = 2'd1,
        EXP1 = 2'd2
    } state_t;

    localparam logic [1:0] MODE_IL  = 2'b00;
    localparam logic [1:0] MODE_CH0 = 2'b01;
    localparam logic [1:0] MODE_CH1 = 2'b10;

    localparam int TIMEOUT_CYC_DEF = 64;

    // Mode 11 is treated as interleave, so only 01 and 10 are single-channel.
    function automatic logic is_single(input logic [1:0] mode);
        return (mode == MODE_CH0) || (mode == MODE_CH1);
    endfunction

    function automatic state_t home_state(input logic [1:0] mode);
        return (mode == MODE_CH1) ? EXP1 : EXP0;
    endfunction

endpackage

// File: rtl/adc_interleave_ctrl_if.sv
// Control/status bundle between the ADC sequencer and its integrating logic.
interface adc_interleave_ctrl_if #(parameter int CNT_W = 16);

    logic             enable;
    logic [1:0]       mode;
    logic             ch_valid_0;
    logic             ch_valid_1;
    logic             err_clear;
    logic             x_adc_select;
    logic             x_adc_valid;
    logic             x_adc_phase;
    logic [CNT_W-1:0] sample_cnt;
    logic             err_order;
    logic             err_timeout;
    logic             busy;

    modport master (
        output enable, mode, ch_valid_0, ch_valid_1, err_clear,
        input  x_adc_select, x_adc_valid, x_adc_phase, sample_cnt,
               err_order, err_timeout, busy
    );

    modport slave (
        input  enable, mode, ch_valid_0, ch_valid_1, err_clear,
        output x_adc_select, x_adc_valid, x_adc_phase, sample_cnt,
               err_order, err_timeout, busy
    );

endinterface

// File: rtl/adc_interleave_ctrl_timeout_cnt.sv
// Idle-cycle counter with clear, increment and terminal-count flag.
module adc_timeout_cnt #(
    parameter int LIMIT = 64,
    parameter int W     = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (inc)
            cnt_q <= cnt_q + 1'b1;
    end

    assign term = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/adc_interleave_ctrl.sv
// Sequencer for the 2-channel interleaved ADC: drives the mux select, output-valid strobe and fault flags.
module adc_interleave_ctrl
    import adc_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = 7,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  GlobalReset,
    adc_interleave_ctrl_if.slave  bus
);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             sel_q, valid_q, phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_order_q, err_timeout_q;

    logic running, single, exp_ch, exp_v, oth_v;
    logic accept, order_err, timeout, to_term;

    assign running = (state_q != IDLE);
    assign single  = is_single(mode_q);
    assign exp_ch  = (state_q == EXP1);
    assign exp_v   = exp_ch ? bus.ch_valid_1 : bus.ch_valid_0;
    assign oth_v   = exp_ch ? bus.ch_valid_0 : bus.ch_valid_1;

    assign accept    = running && exp_v;
    // In single-channel mode the other strobe is simply not ours to judge.
    assign order_err = running && !single && oth_v;
    assign timeout   = running && to_term && !accept;

    adc_timeout_cnt #(.LIMIT(TIMEOUT_CYC), .W(TO_W)) u_timeout (
        .clk  (clk),
        .rst  (GlobalReset),
        .clr  (!running || accept || timeout),
        .inc  (running),
        .term (to_term)
    );

    // NOTE: defaults first so every path assigns state_d/mode_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    mode_d  = bus.mode;
                    state_d = home_state(bus.mode);
                end
            end
            EXP0, EXP1: begin
                if (!bus.enable)
                    state_d = IDLE;
                else if (accept && !single)
                    state_d = exp_ch ? EXP0 : EXP1;
                else if (timeout)
                    state_d = home_state(mode_q);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q       <= IDLE;
            mode_q        <= MODE_IL;
            sel_q         <= 1'b0;
            valid_q       <= 1'b0;
            phase_q       <= 1'b0;
            cnt_q         <= '0;
            err_order_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            sel_q         <= (state_d == EXP1);
            valid_q       <= accept;
            if (accept)
                phase_q   <= exp_ch;
            cnt_q         <= cnt_q + CNT_W'(accept);
            err_order_q   <= order_err | (err_order_q & ~bus.err_clear);
            err_timeout_q <= timeout | (err_timeout_q & ~bus.err_clear);
        end
    end

    assign bus.x_adc_select = sel_q;
    assign bus.x_adc_valid  = valid_q;
    assign bus.x_adc_phase  = phase_q;
    assign bus.sample_cnt   = cnt_q;
    assign bus.err_order    = err_order_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.busy         = running;

endmodule

// File: tb/tb_adc_interleave_ctrl.sv
// Self-checking bench for adc_interleave_ctrl against a cycle-level behavioural model.
module tb_adc_interleave_ctrl;

    localparam int TO   = 8;
    localparam int CW   = 16;
    localparam int CMOD = 1 << CW;

    logic clk = 1'b0;
    logic GlobalReset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    adc_interleave_ctrl_if #(.CNT_W(CW)) bus ();

    adc_interleave_ctrl #(.TIMEOUT_CYC(TO), .TO_W(4), .CNT_W(CW)) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: what the downstream consumer should see.
    bit m_run;
    int m_exp, m_mode, m_idle, m_cnt;
    bit m_valid, m_phase, m_sel, m_eo, m_et;

    task automatic model_reset();
        m_run = 0; m_exp = 0; m_mode = 0; m_idle = 0; m_cnt = 0;
        m_valid = 0; m_phase = 0; m_sel = 0; m_eo = 0; m_et = 0;
    endtask

    task automatic model_edge(input bit en, input int md, input bit v0, input bit v1, input bit clr);
        bit single, acc, oe, to;
        if (!m_run) begin
            m_valid = 0;
            m_idle  = 0;
            m_eo    = m_eo && !clr;
            m_et    = m_et && !clr;
            if (en) begin
                m_mode = md;
                m_run  = 1;
                m_exp  = (md == 2) ? 1 : 0;
            end
        end else begin
            single  = (m_mode == 1) || (m_mode == 2);
            acc     = (m_exp == 1) ? v1 : v0;
            oe      = !single && ((m_exp == 1) ? v0 : v1);
            to      = !acc && (m_idle == TO - 1);
            m_valid = acc;
            if (acc) m_phase = (m_exp == 1);
            if (acc) m_cnt = (m_cnt + 1) % CMOD;
            m_eo    = oe || (m_eo && !clr);
            m_et    = to || (m_et && !clr);
            m_idle  = (acc || to) ? 0 : m_idle + 1;
            if (!en) begin
                m_run  = 0;
                m_idle = 0;
            end else if (acc && !single) begin
                m_exp = 1 - m_exp;
            end else if (to) begin
                m_exp = (m_mode == 2) ? 1 : 0;
            end
        end
        m_sel = m_run && (m_exp == 1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        chk("select", 32'(bus.x_adc_select), 32'(m_sel));
        chk("valid", 32'(bus.x_adc_valid), 32'(m_valid));
        if (m_valid) chk("phase", 32'(bus.x_adc_phase), 32'(m_phase));
        chk("sample_cnt", 32'(bus.sample_cnt), 32'(m_cnt));
        chk("err_order", 32'(bus.err_order), 32'(m_eo));
        chk("err_timeout", 32'(bus.err_timeout), 32'(m_et));
        chk("busy", 32'(bus.busy), 32'(m_run));
    endtask

    // Called at posedge+1: drive inputs, take one edge, update model, compare.
    task automatic step(input bit en, input int md, input bit v0, input bit v1, input bit clr);
        bus.enable     = en;
        bus.mode       = 2'(md);
        bus.ch_valid_0 = v0;
        bus.ch_valid_1 = v1;
        bus.err_clear  = clr;
        @(posedge clk);
        model_edge(en, md, v0, v1, clr);
        #1;
        compare_all();
    endtask

    initial begin
        bus.enable = 0; bus.mode = 2'b00; bus.ch_valid_0 = 0; bus.ch_valid_1 = 0; bus.err_clear = 0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk); #1;
        GlobalReset = 0;
        @(posedge clk); #1;
        compare_all();

        // Interleaved back-to-back ch0,ch1,ch0,ch1.
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        chk("tp1_cnt", 32'(bus.sample_cnt), 32'd4);

        // Wrong channel in EXP0, then clear.
        step(1, 0, 0, 1, 0);
        chk("tp2_order", 32'(bus.err_order), 32'd1);
        step(1, 0, 0, 0, 1);
        chk("tp2_clear", 32'(bus.err_order), 32'd0);

        // Timeout from a fresh start.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < TO; i++) step(1, 0, 0, 0, 0);
        chk("tp3_timeout", 32'(bus.err_timeout), 32'd1);
        step(1, 0, 1, 0, 1);
        chk("tp3_accept", 32'(bus.x_adc_valid), 32'd1);

        // ch1-only with concurrent ch0 strobes.
        step(0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 2, 1, 1, 0);
        step(1, 2, 0, 1, 0);
        step(1, 2, 1, 1, 0);
        step(1, 2, 0, 0, 0);
        chk("tp4_order", 32'(bus.err_order), 32'd0);

        // Run the counter up to its wrap point.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        while (m_cnt != CMOD - 1) step(1, 0, m_exp == 0, m_exp == 1, 0);
        chk("tp5_full", 32'(bus.sample_cnt), 32'hFFFF);
        step(1, 0, m_exp == 0, m_exp == 1, 0);
        chk("tp5_wrap", 32'(bus.sample_cnt), 32'h0);
        chk("tp5_valid", 32'(bus.x_adc_valid), 32'd1);

        // Drop enable together with an accept.
        step(0, 0, m_exp == 0, m_exp == 1, 0);
        chk("tp6_valid", 32'(bus.x_adc_valid), 32'd1);
        chk("tp6_busy", 32'(bus.busy), 32'd0);

        // Random traffic across modes, with occasional disables and clears.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) != 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0);

        // Asynchronous reset mid-run, with a valid pulse in flight.
        step(1, 0, 0, 0, 0);
        step(1, 0, m_exp == 0, m_exp == 1, 0);
        #2;
        GlobalReset = 1;
        #1;
        model_reset();
        compare_all();
        chk("tp6_rst_valid", 32'(bus.x_adc_valid), 32'd0);
        bus.enable = 0; bus.ch_valid_0 = 0; bus.ch_valid_1 = 0;
        #1;
        GlobalReset = 0;
        @(posedge clk); #1;
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/adc_interleave_ctrl.md
Name: adc_interleave_ctrl

Overview:
Sequencer for the 2-channel time-interleaved ADC front end. It tracks per-channel sample-valid strobes and drives the select line of the registered 2:1 x_adc mux so that samples leave in strict ch0/ch1 order. It emits an output-valid strobe aligned to the mux's 1-cycle latency, and flags ordering and timeout faults. It sits between the two ADC channel interfaces and the interleave mux, in the same clk domain.

Parameters:
TIMEOUT_CYC, 64, max cycles allowed between accepted samples while running before err_timeout fires
TO_W, 7, width of the timeout counter; must hold TIMEOUT_CYC
CNT_W, 16, width of the accepted-sample counter

Ports:
clk  in  1  system clock, rising edge
GlobalReset  in  1  asynchronous, active-high reset
enable  in  1  run request; low returns the FSM to IDLE
mode  in  2  00 = interleave ch0/ch1, 01 = ch0 only, 10 = ch1 only, 11 = treated as 00
ch_valid_0  in  1  ch0 sample present on x_adc_0 this cycle
ch_valid_1  in  1  ch1 sample present on x_adc_1 this cycle
err_clear  in  1  clears the sticky error flags
x_adc_select  out  1  mux select, registered; equals the expected channel
x_adc_valid  out  1  1-cycle pulse; the mux output x_adc holds an accepted sample this cycle
x_adc_phase  out  1  channel of the sample flagged by x_adc_valid
sample_cnt  out  CNT_W  count of accepted samples, wraps
err_order  out  1  sticky: valid seen from the non-expected channel
err_timeout  out  1  sticky: no accepted sample within TIMEOUT_CYC cycles
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, GlobalReset = 1): state IDLE; all outputs 0; timeout counter 0; latched mode 00.
- States:
  - IDLE: while enable = 0, stay. When enable = 1, latch mode; go to EXP0 if the latched mode is 00, 01 or 11; go to EXP1 if it is 10. mode changes outside IDLE are ignored.
  - EXP0: x_adc_select = 0.
  - EXP1: x_adc_select = 1.
  - x_adc_select is a registered output. It is updated on the same edge as the state, so it is stable for the whole cycle in which the expected sample arrives.
- Accept: a sample is accepted when the strobe of the expected channel is 1 in EXPk. On that edge:
  - the mux captures the sample;
  - x_adc_valid = 1 and x_adc_phase = k during the following cycle, which is exactly when the mux output is valid (latency 1);
  - sample_cnt increments, wrapping from 2^CNT_W-1 to 0;
  - the timeout counter clears;
  - in interleave mode the state toggles EXP0 <-> EXP1; in single-channel mode it stays.
- Back-to-back: a valid on every cycle alternating 0,1,0,1 is accepted at full rate, with no bubble.
- Wrong channel: a strobe from the non-expected channel alone sets err_order. The sample is not accepted, the state does not change, and x_adc_valid is not pulsed.
- Single-channel mode: the unused channel's strobe is ignored and never flags an error.
- Both strobes high in the same cycle:
  - interleave mode: accept the expected channel and set err_order;
  - single-channel mode: accept the selected channel, no error.
- Timeout: in EXPk the counter increments each cycle with no accept. When it reaches TIMEOUT_CYC-1:
  - err_timeout is set;
  - the state goes to EXP0, or to EXP1 for mode 10, i.e. resynchronises;
  - the counter clears.
- Sticky flags: err_clear = 1 clears both flags at the next edge. If a set condition occurs in the same cycle, set wins.
- enable = 0 while running: go to IDLE at the next edge and drive x_adc_select to 0 then. An accept in that same cycle still completes, so x_adc_valid still pulses next cycle. sample_cnt holds.
- Reset asserted mid-run: immediate return to the reset state. Any in-flight x_adc_valid is dropped.
- busy = 1 in any state other than IDLE.

Decomposition:
- Shared package adc_pkg:
  - state encoding IDLE = 2'd0, EXP0 = 2'd1, EXP1 = 2'd2;
  - mode constants MODE_IL = 2'b00, MODE_CH0 = 2'b01, MODE_CH1 = 2'b10;
  - TIMEOUT_CYC default.
- One natural sub-module: adc_timeout_cnt. It is a counter with clear, increment and terminal flag, reusable for wider interleave factors.
- The mux stays a separate instance at the integration level. This block only drives its select.

Test Plan:
1. Reset, then mode = 00, enable = 1. Strobes ch0, ch1, ch0, ch1 on consecutive cycles. Expect:
   - select sequence 0,1,0,1;
   - x_adc_valid high for 4 cycles, starting 1 cycle after the first strobe;
   - phase 0,1,0,1;
   - sample_cnt = 4;
   - no errors.
2. In EXP0, assert ch_valid_1 only. Expect err_order = 1, no valid pulse, select remains 0, state EXP0. Then assert err_clear. Expect err_order = 0 next cycle.
3. TIMEOUT_CYC = 8, enable in mode 00, no strobes. Expect err_timeout = 1 after 8 cycles in EXP0 and the state remains EXP0. Then assert ch_valid_0. Expect a normal accept.
4. Mode = 10, strobes on ch1 for 3 cycles plus a concurrent ch0 strobe. Expect:
   - select held at 1;
   - 3 valid pulses with phase = 1;
   - err_order = 0.
5. Preset sample_cnt to 0xFFFF, one accept. Expect sample_cnt = 0x0000 and the valid pulse still issued.
6. Drop enable in the same cycle as an accept. Expect the valid pulse next cycle, select = 0 and busy = 0. Then assert GlobalReset asynchronously mid-run. Expect all outputs 0 immediately, without waiting for a clock edge.
